datapath_sequencer: RTL and testbench

//  Multi-cycle controller that drives the datapath (register bank + ALU) for one instruction at a time.

---
 rtl/datapath_sequencer.sv | 154 +++++++++++++++
 tb/tb_datapath_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_sequencer
//  Description : Multi-cycle controller that steps one decoded instruction at
//                a time through READ, EXEC and WB against an external register
//                bank + ALU. Supports register-register ALU ops (op=0) and
//                load-immediate (op=1).
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                instr_valid/ready     - decode-side handshake
//                instr_op/rs1/rs2/rd/alu/imm - instruction fields (latched
//                                        on accept, ignored otherwise)
//                rs_1, rs_2, rd_0      - datapath register addresses
//                alu_control           - datapath ALU function
//                write_rb, writedata   - datapath register write port
//                alu_result            - datapath ALU output
//                done, result          - retire pulse and retired value
//                retired_cnt           - wrapping retired-instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_sequencer #(
    parameter int EXEC_CYCLES = 2,   // legal range 1..15 (4-bit down-counter)
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             instr_op,
    input  logic [4:0]       instr_rs1,
    input  logic [4:0]       instr_rs2,
    input  logic [4:0]       instr_rd,
    input  logic [2:0]       instr_alu,
    input  logic [31:0]      instr_imm,
    output logic [4:0]       rs_1,
    output logic [4:0]       rs_2,
    output logic [4:0]       rd_0,
    output logic [2:0]       alu_control,
    output logic             write_rb,
    output logic [31:0]      writedata,
    input  logic [31:0]      alu_result,
    output logic             done,
    output logic [31:0]      result,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_READ = 3'd1;
    localparam logic [2:0] c_ST_EXEC = 3'd2;
    localparam logic [2:0] c_ST_WB   = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    // EXEC lasts EXEC_CYCLES cycles: load N-1 and leave when the count hits 0.
    localparam logic [3:0] c_EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic             w_accept;

    logic             r_op;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [2:0]       r_alu;
    logic [31:0]      r_imm;
    logic [3:0]       r_exec_cnt;
    logic [31:0]      r_result_q;
    logic             r_write_rb;
    logic             r_done;
    logic [31:0]      r_result;
    logic [CNT_W-1:0] r_retired_cnt;
    logic [31:0]      w_writedata;

    assign w_accept = instr_valid && (r_state == c_ST_IDLE);

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_next = c_ST_READ;
            c_ST_READ: w_state_next = r_op ? c_ST_WB : c_ST_EXEC;
            c_ST_EXEC: if (r_exec_cnt == 4'd0) w_state_next = c_ST_WB;
            c_ST_WB:   w_state_next = c_ST_DONE;
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // Write data is a pure function of latched registers, so it never
    // glitches and naturally holds its last value while idle.
    assign w_writedata = r_op ? r_imm : r_result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_op          <= 1'b0;
            r_rs1         <= 5'd0;
            r_rs2         <= 5'd0;
            r_rd          <= 5'd0;
            r_alu         <= 3'd0;
            r_imm         <= 32'd0;
            r_exec_cnt    <= 4'd0;
            r_result_q    <= 32'd0;
            r_write_rb    <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= 32'd0;
            r_retired_cnt <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_op  <= instr_op;
                r_rs1 <= instr_rs1;
                r_rs2 <= instr_rs2;
                r_rd  <= instr_rd;
                r_alu <= instr_alu;
                r_imm <= instr_imm;
            end

            if (r_state == c_ST_READ) begin
                r_exec_cnt <= c_EXEC_LOAD;
            end else if ((r_state == c_ST_EXEC) && (r_exec_cnt != 4'd0)) begin
                r_exec_cnt <= r_exec_cnt - 4'd1;
            end

            // Operands have been stable for EXEC_CYCLES cycles on the last one.
            if ((r_state == c_ST_EXEC) && (r_exec_cnt == 4'd0)) begin
                r_result_q <= alu_result;
            end

            // Strobes are registered off the next state so they coincide
            // exactly with the WB / DONE cycles. x0 is never written.
            r_write_rb <= (w_state_next == c_ST_WB) && (r_rd != 5'd0);
            r_done     <= (w_state_next == c_ST_DONE);

            if (r_state == c_ST_WB) begin
                r_result      <= w_writedata;
                r_retired_cnt <= r_retired_cnt + CNT_W'(1);
            end
        end
    end

    assign instr_ready = (r_state == c_ST_IDLE);
    assign rs_1        = r_rs1;
    assign rs_2        = r_rs2;
    assign rd_0        = r_rd;
    assign alu_control = r_alu;
    assign write_rb    = r_write_rb;
    assign writedata   = w_writedata;
    assign done        = r_done;
    assign result      = r_result;
    assign retired_cnt = r_retired_cnt;

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_sequencer
//  Description : Self-checking bench for datapath_sequencer. Instance A uses
//                the default build; instance B uses EXEC_CYCLES=1, CNT_W=2 to
//                exercise the short EXEC path and counter wrap. Each instance
//                is paired with a small register-bank + ALU model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rf_init;
    logic        valid_a, valid_b;
    logic        op;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  alu;
    logic [31:0] imm;

    logic        ready_a, wr_a, done_a;
    logic [4:0]  rs_1_a, rs_2_a, rd_0_a;
    logic [2:0]  aluc_a;
    logic [31:0] wdata_a, res_a, alu_res_a;
    logic [15:0] cnt_a;

    logic        ready_b, wr_b, done_b;
    logic [4:0]  rs_1_b, rs_2_b, rd_0_b;
    logic [2:0]  aluc_b;
    logic [31:0] wdata_b, res_b, alu_res_b;
    logic [1:0]  cnt_b;

    datapath_sequencer #(.EXEC_CYCLES(2), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .instr_valid(valid_a), .instr_ready(ready_a),
        .instr_op(op), .instr_rs1(rs1), .instr_rs2(rs2), .instr_rd(rd),
        .instr_alu(alu), .instr_imm(imm), .rs_1(rs_1_a), .rs_2(rs_2_a),
        .rd_0(rd_0_a), .alu_control(aluc_a), .write_rb(wr_a),
        .writedata(wdata_a), .alu_result(alu_res_a), .done(done_a),
        .result(res_a), .retired_cnt(cnt_a)
    );

    datapath_sequencer #(.EXEC_CYCLES(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .instr_valid(valid_b), .instr_ready(ready_b),
        .instr_op(op), .instr_rs1(rs1), .instr_rs2(rs2), .instr_rd(rd),
        .instr_alu(alu), .instr_imm(imm), .rs_1(rs_1_b), .rs_2(rs_2_b),
        .rd_0(rd_0_b), .alu_control(aluc_b), .write_rb(wr_b),
        .writedata(wdata_b), .alu_result(alu_res_b), .done(done_b),
        .result(res_b), .retired_cnt(cnt_b)
    );

    // Datapath models: register bank with hard-wired x0 plus a small ALU.
    logic [31:0] rf_a [32];
    logic [31:0] rf_b [32];

    function automatic logic [31:0] alu_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res_a = alu_fn(aluc_a, (rs_1_a == 5'd0) ? 32'd0 : rf_a[rs_1_a],
                                      (rs_2_a == 5'd0) ? 32'd0 : rf_a[rs_2_a]);
    assign alu_res_b = alu_fn(aluc_b, (rs_1_b == 5'd0) ? 32'd0 : rf_b[rs_1_b],
                                      (rs_2_b == 5'd0) ? 32'd0 : rf_b[rs_2_b]);

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) begin
                rf_a[i] <= 32'd0;
                rf_b[i] <= 32'd0;
            end
            rf_b[1]  <= 32'd2;
            rf_b[31] <= 32'd64;
        end else begin
            if (wr_a && rd_0_a != 5'd0) rf_a[rd_0_a] <= wdata_a;
            if (wr_b && rd_0_b != 5'd0) rf_b[rd_0_b] <= wdata_b;
        end
    end

    // Instance selection for the shared issue task.
    logic        sel;
    logic        ready_s, wr_s, done_s;
    logic [4:0]  rs_1_s, rs_2_s, rd_0_s;
    logic [2:0]  aluc_s;
    logic [31:0] wdata_s, res_s, cnt_s;
    assign ready_s = sel ? ready_b : ready_a;
    assign wr_s    = sel ? wr_b    : wr_a;
    assign done_s  = sel ? done_b  : done_a;
    assign rs_1_s  = sel ? rs_1_b  : rs_1_a;
    assign rs_2_s  = sel ? rs_2_b  : rs_2_a;
    assign rd_0_s  = sel ? rd_0_b  : rd_0_a;
    assign aluc_s  = sel ? aluc_b  : aluc_a;
    assign wdata_s = sel ? wdata_b : wdata_a;
    assign res_s   = sel ? res_b   : res_a;
    assign cnt_s   = sel ? {30'd0, cnt_b} : {16'd0, cnt_a};

    int total = 0;
    int bad   = 0;
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one instruction, then watch it until done (bounded).
    task automatic run_instr(input logic s, input logic iop, input logic [4:0] irs1,
                             input logic [4:0] irs2, input logic [4:0] ird,
                             input logic [2:0] ialu, input logic [31:0] iimm,
                             input logic exp_wr, input logic [31:0] exp_val,
                             input string tag);
        int exec_c, exp_wb, exp_done, wr_n, wr_cyc, done_cyc, held_bad;
        logic [4:0]  wr_rd;
        logic [31:0] wr_data, res_v, cnt_v, exp_cnt;
        exec_c   = s ? 1 : 2;
        exp_wb   = iop ? 2 : exec_c + 2;
        exp_done = exp_wb + 1;
        wr_n = 0; wr_cyc = 0; done_cyc = 0; held_bad = 0;
        wr_rd = 5'd0; wr_data = 32'd0; res_v = 32'd0; cnt_v = 32'd0;
        sel = s;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, ready_s}, 32'd1);
        op = iop; rs1 = irs1; rs2 = irs2; rd = ird; alu = ialu; imm = iimm;
        if (s) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0; valid_b = 1'b0;
        // Fields must be ignored after accept.
        op = ~iop; rs1 = ~irs1; rs2 = ~irs2; rd = ~ird; alu = ~ialu; imm = ~iimm;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c < exp_wb && (rs_1_s !== irs1 || rs_2_s !== irs2 || aluc_s !== ialu))
                held_bad++;
            if (wr_s) begin wr_n++; wr_cyc = c; wr_rd = rd_0_s; wr_data = wdata_s; end
            if (done_s) begin done_cyc = c; res_v = res_s; cnt_v = cnt_s; break; end
        end
        if (s) begin exp_cnt_b++; exp_cnt = exp_cnt_b & 3; end
        else   begin exp_cnt_a++; exp_cnt = exp_cnt_a & 16'hFFFF; end
        chk({tag, "_operands_held"}, held_bad, 0);
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_write_count"}, wr_n, {31'd0, exp_wr});
        if (exp_wr) begin
            chk({tag, "_wb_cycle"}, wr_cyc, exp_wb);
            chk({tag, "_rd_0"}, {27'd0, wr_rd}, {27'd0, ird});
            chk({tag, "_writedata"}, wr_data, exp_val);
        end
        chk({tag, "_result"}, res_v, exp_val);
        chk({tag, "_retired_cnt"}, cnt_v, exp_cnt);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {31'd0, done_s}, 32'd0);
    endtask

    typedef struct {
        logic        op;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  alu;
        logic [31:0] imm;
        logic        wr;
        logic [31:0] val;
    } vec_t;

    vec_t vt [11];

    int acc, dn, wrn, evt;
    logic go;

    initial begin
        // {op, rs1, rs2, rd, alu, imm, writes, expected value}
        vt[0]  = '{1'b1, 5'd0, 5'd0, 5'd5,  3'b010, 32'h0000000C, 1'b1, 32'd12};
        vt[1]  = '{1'b1, 5'd0, 5'd0, 5'd3,  3'b010, 32'd8,        1'b1, 32'd8};
        vt[2]  = '{1'b1, 5'd0, 5'd0, 5'd7,  3'b010, 32'd14,       1'b1, 32'd14};
        vt[3]  = '{1'b0, 5'd3, 5'd7, 5'd9,  3'b010, 32'd0,        1'b1, 32'd22};
        vt[4]  = '{1'b1, 5'd0, 5'd0, 5'd0,  3'b010, 32'h000000FF, 1'b0, 32'hFF};
        vt[5]  = '{1'b0, 5'd0, 5'd9, 5'd10, 3'b010, 32'd0,        1'b1, 32'd22};
        vt[6]  = '{1'b0, 5'd7, 5'd3, 5'd11, 3'b110, 32'd0,        1'b1, 32'd6};
        vt[7]  = '{1'b0, 5'd3, 5'd7, 5'd12, 3'b000, 32'd0,        1'b1, 32'd8};
        vt[8]  = '{1'b0, 5'd3, 5'd7, 5'd0,  3'b010, 32'd0,        1'b0, 32'd22};
        vt[9]  = '{1'b1, 5'd0, 5'd0, 5'd1,  3'b010, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};
        vt[10] = '{1'b0, 5'd1, 5'd3, 5'd2,  3'b010, 32'd0,        1'b1, 32'd7};

        sel = 1'b0; rst = 1'b1; rf_init = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
        op = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; alu = 3'd0; imm = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",     {31'd0, ready_a}, 32'd1);
        chk("rst_write_rb",  {31'd0, wr_a},    32'd0);
        chk("rst_done",      {31'd0, done_a},  32'd0);
        chk("rst_rs_1",      {27'd0, rs_1_a},  32'd0);
        chk("rst_writedata", wdata_a,          32'd0);
        chk("rst_result",    res_a,            32'd0);
        chk("rst_cnt",       {16'd0, cnt_a},   32'd0);
        rst = 1'b0; rf_init = 1'b0;

        for (int i = 0; i < 11; i++)
            run_instr(1'b0, vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].alu,
                      vt[i].imm, vt[i].wr, vt[i].val, $sformatf("vec%0d", i));
        chk("x0_untouched", rf_a[0], 32'd0);
        chk("x9_value", rf_a[9], 32'd22);

        // Three queued instructions with instr_valid held high.
        sel = 1'b0; acc = 0; dn = 0; wrn = 0;
        @(negedge clk);
        op = 1'b1; rd = 5'd13; imm = 32'd1; valid_a = 1'b1;
        for (int c = 0; c < 100 && dn < 3; c++) begin
            go = valid_a && ready_a;
            @(posedge clk); #1;
            if (go) begin
                acc++;
                if (acc == 1) begin op = 1'b1; rd = 5'd14; imm = 32'd2; end
                else if (acc == 2) begin op = 1'b0; rs1 = 5'd13; rs2 = 5'd14; rd = 5'd15; alu = 3'b010; end
                else valid_a = 1'b0;
            end
            @(negedge clk);
            if (wr_a) wrn++;
            if (done_a) dn++;
        end
        exp_cnt_a += 3;
        chk("queue_accepts", acc, 3);
        chk("queue_dones", dn, 3);
        chk("queue_writes", wrn, 3);
        chk("queue_cnt", {16'd0, cnt_a}, exp_cnt_a & 16'hFFFF);
        chk("queue_x15", rf_a[15], 32'd3);

        // Reset during EXEC abandons the instruction.
        @(negedge clk);
        op = 1'b0; rs1 = 5'd3; rs2 = 5'd7; rd = 5'd20; alu = 3'b010; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, ready_a}, 32'd1);
        chk("mid_rst_write_rb", {31'd0, wr_a}, 32'd0);
        chk("mid_rst_done", {31'd0, done_a}, 32'd0);
        chk("mid_rst_cnt", {16'd0, cnt_a}, 32'd0);
        exp_cnt_a = 0; exp_cnt_b = 0;
        evt = 0;
        repeat (8) begin
            @(negedge clk);
            if (wr_a || done_a) evt++;
        end
        chk("mid_rst_no_events", evt, 0);
        chk("mid_rst_x20", rf_a[20], 32'd0);

        // Short-EXEC build with 2-bit counter: bring count to all-ones, then wrap.
        run_instr(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 3'b010, 32'd5, 1'b0, 32'd5, "b_li0");
        run_instr(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 3'b010, 32'd6, 1'b0, 32'd6, "b_li1");
        run_instr(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 3'b010, 32'd7, 1'b0, 32'd7, "b_li2");
        chk("b_cnt_all_ones", {30'd0, cnt_b}, 32'd3);
        run_instr(1'b1, 1'b0, 5'd1, 5'd31, 5'd4, 3'b010, 32'd0, 1'b1, 32'd66, "b_add");
        chk("b_cnt_wrap", {30'd0, cnt_b}, 32'd0);
        chk("b_x4", rf_b[4], 32'd66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
